// File: rtl/logicap_pkg.sv
// rtl/logicap_pkg.sv - shared types and constants for the logic analyser capture path
package logicap_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_CAPTURE,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam logic TRIG_LEVEL = 1'b0;
    localparam logic TRIG_EDGE  = 1'b1;

endpackage

// File: rtl/axis_skid_out.sv
// rtl/axis_skid_out.sv - two-entry stream output buffer that drops instead of back-pressuring
module axis_skid_out #(
    parameter int dataw = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [dataw-1:0] push_data,
    input  logic             push_last,
    output logic             drop,
    output logic [dataw-1:0] m_tdata,
    output logic             m_tvalid,
    output logic             m_tlast,
    input  logic             m_tready
);

    logic [dataw-1:0] out_data_q, out_data_d;
    logic             out_last_q, out_last_d;
    logic             out_valid_q, out_valid_d;
    logic [dataw-1:0] hold_data_q, hold_data_d;
    logic             hold_last_q, hold_last_d;
    logic             hold_valid_q, hold_valid_d;

    always_comb begin
        out_data_d   = out_data_q;
        out_last_d   = out_last_q;
        out_valid_d  = out_valid_q;
        hold_data_d  = hold_data_q;
        hold_last_d  = hold_last_q;
        hold_valid_d = hold_valid_q;
        drop         = 1'b0;

        if (out_valid_q && m_tready) begin
            out_valid_d = 1'b0;
        end

        if (flush) begin
            hold_valid_d = 1'b0;
        end else if (!out_valid_d && hold_valid_q) begin
            out_data_d   = hold_data_q;
            out_last_d   = hold_last_q;
            out_valid_d  = 1'b1;
            hold_valid_d = 1'b0;
        end

        // Occupancy is judged after the handshake has freed its entry.
        if (push) begin
            if (!out_valid_d) begin
                out_data_d  = push_data;
                out_last_d  = push_last;
                out_valid_d = 1'b1;
            end else if (!hold_valid_d) begin
                hold_data_d  = push_data;
                hold_last_d  = push_last;
                hold_valid_d = 1'b1;
            end else begin
                drop = 1'b1;
                if (push_last) begin
                    hold_data_d = push_data;
                    hold_last_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            hold_data_q  <= '0;
            hold_last_q  <= 1'b0;
            hold_valid_q <= 1'b0;
        end else begin
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            out_valid_q  <= out_valid_d;
            hold_data_q  <= hold_data_d;
            hold_last_q  <= hold_last_d;
            hold_valid_q <= hold_valid_d;
        end
    end

    assign m_tdata  = out_data_q;
    assign m_tvalid = out_valid_q;
    assign m_tlast  = out_last_q;

endmodule

// File: rtl/logicap_capture.sv
// rtl/logicap_capture.sv - probe sampling, masked trigger and fixed-length window streaming
module logicap_capture
    import logicap_pkg::*;
#(
    parameter int dataw = 32,
    parameter int lenw  = 16,
    parameter int dropw = 16
) (
    input  logic             slave_clk,
    input  logic             reset,
    input  logic [dataw-1:0] probe,
    input  logic             sample_en,
    input  logic             arm,
    input  logic             abort,
    input  logic [lenw-1:0]  capture_len,
    input  logic [dataw-1:0] trig_mask,
    input  logic [dataw-1:0] trig_value,
    input  logic             trig_edge,
    output logic [dataw-1:0] m_tdata,
    output logic             m_tvalid,
    output logic             m_tlast,
    input  logic             m_tready,
    output logic             busy,
    output logic             triggered,
    output logic             done,
    output logic             overrun,
    output logic [dropw-1:0] drop_count
);

    state_t           state_q, state_d;
    logic [lenw-1:0]  len_q, len_d;
    logic [lenw-1:0]  count_q, count_d;
    logic             edge_q, edge_d;
    logic             prev_match_q, prev_match_d;
    logic             triggered_q, triggered_d;
    logic             done_q, done_d;
    logic             overrun_q, overrun_d;
    logic [dropw-1:0] drop_count_q, drop_count_d;

    logic             match;
    logic             trig;
    logic [lenw-1:0]  count_inc;
    logic             push, push_last, flush, drop;

    assign match     = ((probe ^ trig_value) & trig_mask) == '0;
    assign count_inc = count_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        count_d      = count_q;
        edge_d       = edge_q;
        prev_match_d = prev_match_q;
        triggered_d  = triggered_q;
        done_d       = done_q;
        overrun_d    = overrun_q;
        drop_count_d = drop_count_q;
        push         = 1'b0;
        push_last    = 1'b0;
        flush        = 1'b0;
        trig         = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (arm && !abort && capture_len != '0) begin
                    len_d        = capture_len;
                    edge_d       = trig_edge;
                    count_d      = '0;
                    prev_match_d = 1'b1;
                    triggered_d  = 1'b0;
                    done_d       = 1'b0;
                    overrun_d    = 1'b0;
                    drop_count_d = '0;
                    state_d      = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (abort) begin
                    flush   = 1'b1;
                    state_d = ST_IDLE;
                end else if (sample_en) begin
                    // prev_match starts at 1 so a level already true at arm is not an edge.
                    trig         = (edge_q == TRIG_EDGE) ? (match && !prev_match_q) : match;
                    prev_match_d = match;
                    if (trig) begin
                        triggered_d = 1'b1;
                        count_d     = lenw'(1);
                        push        = 1'b1;
                        push_last   = (len_q == lenw'(1));
                        state_d     = (len_q == lenw'(1)) ? ST_DRAIN : ST_CAPTURE;
                    end
                end
            end
            ST_CAPTURE: begin
                if (abort) begin
                    flush   = 1'b1;
                    state_d = ST_IDLE;
                end else if (sample_en) begin
                    count_d   = count_inc;
                    push      = 1'b1;
                    push_last = (count_inc == len_q);
                    if (count_inc == len_q) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (abort) begin
                    flush   = 1'b1;
                    state_d = ST_IDLE;
                end else if (m_tvalid && m_tready && m_tlast) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (drop) begin
            overrun_d = 1'b1;
            if (drop_count_q != '1) begin
                drop_count_d = drop_count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge slave_clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            len_q        <= '0;
            count_q      <= '0;
            edge_q       <= TRIG_LEVEL;
            prev_match_q <= 1'b1;
            triggered_q  <= 1'b0;
            done_q       <= 1'b0;
            overrun_q    <= 1'b0;
            drop_count_q <= '0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            count_q      <= count_d;
            edge_q       <= edge_d;
            prev_match_q <= prev_match_d;
            triggered_q  <= triggered_d;
            done_q       <= done_d;
            overrun_q    <= overrun_d;
            drop_count_q <= drop_count_d;
        end
    end

    axis_skid_out #(
        .dataw(dataw)
    ) u_skid (
        .clk       (slave_clk),
        .reset     (reset),
        .flush     (flush),
        .push      (push),
        .push_data (probe),
        .push_last (push_last),
        .drop      (drop),
        .m_tdata   (m_tdata),
        .m_tvalid  (m_tvalid),
        .m_tlast   (m_tlast),
        .m_tready  (m_tready)
    );

    assign busy       = (state_q != ST_IDLE && state_q != ST_DONE) || m_tvalid;
    assign triggered  = triggered_q;
    assign done       = done_q;
    assign overrun    = overrun_q;
    assign drop_count = drop_count_q;

endmodule
